// File: rtl/buffer_service_scheduler.sv
// Service scheduler for four 6-slot request buffers.
// Selection policy: longest queue first, with a round-robin tie-break and a
// starvation guard. The grant is held until the server reports done or the
// timeout expires.
module buffer_service_scheduler #(
  parameter int MAX_SKIP = 3,
  parameter int TIMEOUT  = 16,
  parameter int SKIP_W   = 3,
  parameter int TMO_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] L1,
  input  logic [2:0] L2,
  input  logic [2:0] L3,
  input  logic [2:0] L4,
  input  logic       enable,
  input  logic       done,
  output logic [3:0] grant,
  output logic [3:0] pop,
  output logic [1:0] served_id,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [SKIP_W-1:0] skip [4];
  logic [TMO_W-1:0]  tmo;

  logic [2:0] occ [4];
  logic [3:0] nonempty;
  logic [3:0] starved;
  logic [3:0] max_set;
  logic [3:0] cand;
  logic [2:0] max_l;
  logic [1:0] winner;
  logic [3:0] winner_oh;

  assign occ[0] = L1;
  assign occ[1] = L2;
  assign occ[2] = L3;
  assign occ[3] = L4;

  // Winner selection: starved buffers take precedence over the longest
  // queues. Either set is resolved by scanning from rr_ptr+1.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    max_l  = 3'd0;
    idx    = 2'd0;
    found  = 1'b0;
    winner = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (occ[i] > max_l) max_l = occ[i];
    end
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (occ[i] != 3'd0);
      starved[i]  = nonempty[i] && (skip[i] >= SKIP_W'(MAX_SKIP));
      max_set[i]  = nonempty[i] && (occ[i] == max_l);
    end
    cand = (|starved) ? starved : max_set;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    winner_oh = 4'b0001 << winner;
  end

  // Two-state service FSM with registered grant/pop/status outputs and
  // per-buffer skip counters that are updated only on a grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 2'd3;
      tmo         <= '0;
      grant       <= 4'b0000;
      pop         <= 4'b0000;
      served_id   <= 2'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 4; i++) skip[i] <= '0;
    end else begin
      pop         <= 4'b0000;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (|nonempty)) begin
            state     <= SERVE;
            grant     <= winner_oh;
            pop       <= winner_oh;
            served_id <= winner;
            rr_ptr    <= winner;
            busy      <= 1'b1;
            tmo       <= '0;
            for (int i = 0; i < 4; i++) begin
              if (2'(i) == winner)     skip[i] <= '0;
              else if (!nonempty[i])   skip[i] <= '0;
              else if (skip[i] != '1)  skip[i] <= skip[i] + SKIP_W'(1);
            end
          end
        end
        SERVE: begin
          if (done) begin
            state <= IDLE;
            grant <= 4'b0000;
            busy  <= 1'b0;
            tmo   <= '0;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            busy        <= 1'b0;
            tmo         <= '0;
            timeout_err <= 1'b1;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/buffer_service_scheduler.md
Name: buffer_service_scheduler

Overview:
- Sequences service of the four 6-slot request buffers. Picks one buffer per service transaction using the per-buffer occupancy counts L1..L4, which are produced combinationally from the buffer valid bits.
- Issues a one-cycle pop and holds a one-hot grant until the downstream server signals done or a timeout fires.
- Policy: longest queue first, with round-robin tie-break and a starvation guard.
- Sits between the occupancy counter and the shared server/datapath.

Parameters:
- MAX_SKIP, 3, number of times a non-empty buffer may be passed over before it is forced to the highest priority.
- TIMEOUT, 16, number of cycles in SERVE without done before the service is aborted.
- SKIP_W, 3, width of each starvation counter; must satisfy MAX_SKIP < 2^SKIP_W.
- TMO_W, 5, width of the timeout counter; must satisfy TIMEOUT < 2^TMO_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- L1  input  3  occupancy of buffer 1 (0..6); value 7 is treated as 7, no clamping.
- L2  input  3  occupancy of buffer 2.
- L3  input  3  occupancy of buffer 3.
- L4  input  3  occupancy of buffer 4.
- enable  input  1  permits new grants; does not abort a service in progress.
- done  input  1  server finished the current service; single-cycle or level, sampled only in SERVE.
- grant  output  4  one-hot registered grant; bit0 = buffer 1.
- pop  output  4  one-cycle one-hot pulse to the granted buffer to remove its head entry.
- served_id  output  2  index of the last granted buffer (0..3).
- busy  output  1  high while in SERVE.
- timeout_err  output  1  one-cycle pulse when a service is aborted by timeout.

Behaviour:
- Reset (async, rst_n=0):
  - outputs: grant=0, pop=0, served_id=0, busy=0, timeout_err=0.
  - state: state=IDLE, rr_ptr=3 (so buffer index 0 wins the first tie), all skip counters=0, timeout counter=0.
  - Reset asserted mid-SERVE drops grant immediately. No pop is reissued after release.
- States: IDLE, SERVE.
- IDLE transition:
  - Condition: enable=1 and any Lx!=0. The winner is computed combinationally from the current L inputs.
  - On the next edge: state->SERVE, grant=onehot(winner), pop=onehot(winner) for exactly one cycle, served_id=winner, rr_ptr=winner, busy=1.
  - Decision-to-grant latency is 1 cycle.
- Winner selection, in priority order:
  1. Starved set: non-empty buffers whose skip counter >= MAX_SKIP. If the set is non-empty, pick the first member found scanning rr_ptr+1, rr_ptr+2, ... modulo 4.
  2. Otherwise: the buffer(s) with maximum Lx (unsigned 3-bit compare). Ties are broken by the same rr_ptr+1 scan.
  3. Empty buffers (Lx=0) are never granted.
- Skip counters, updated on the grant edge only:
  - Granted buffer: cleared.
  - Each other buffer with Lx!=0: incremented, saturating at 2^SKIP_W-1.
  - Each other buffer with Lx=0: cleared.
- SERVE state:
  - pop is low after its first cycle.
  - grant is held and the timeout counter increments each cycle.
  - done=1 on any SERVE cycle, including the first: next edge state->IDLE, grant=0, busy=0, timeout counter cleared.
  - Timeout counter reaches TIMEOUT-1 without done: next edge state->IDLE, grant=0, busy=0, timeout_err=1 for one cycle. Skip counters unchanged.
  - done and timeout in the same cycle: done wins, no timeout_err.
  - The granted buffer's occupancy dropping to 0, or enable falling, does not end SERVE.
- Back-to-back: at least one IDLE cycle between services. Maximum grant rate is 1 per 2 cycles.
- done while in IDLE: ignored.
- enable=0 in IDLE: no grant; skip counters hold.
- Invariants: grant is one-hot or zero; pop is asserted only as a subset of grant.

Test Plan:
- Reset, then L=(0,0,0,0) with enable=1 for 10 cycles -> grant=0, pop=0, busy=0 throughout.
- L=(2,5,1,0), enable=1 -> one cycle later grant=4'b0010, pop=4'b0010 for 1 cycle, served_id=1. Pulse done 3 cycles later -> grant=0 on the following edge.
- L held at (3,3,3,3) with done returned every SERVE's first cycle -> grants rotate buffer 1,2,3,4,1 (grant 0001,0010,0100,1000,0001).
- L held at (1,6,0,0) with immediate done, MAX_SKIP=3 -> grant sequence buf2, buf2, buf2, buf1, buf2: buffer 1 is forced after 3 skips.
- Grant buf3, done never asserted, TIMEOUT=16 -> after 16 SERVE cycles grant=0 and timeout_err pulses for exactly 1 cycle. Next grant follows normal selection.
- Grant issued, then rst_n pulled low mid-SERVE -> grant, busy, pop go to 0 asynchronously. After release the first grant uses rr_ptr=3 tie-break (buffer 1 wins a 4-way tie).
